// File: rtl/hazard_unit.sv
// Hazard detection for the ID stage: load/ALU-to-use stalls, the extra
// stall cycle a load feeding a branch or JALR needs, and branch mispredict
// squash of IF/ID.
module hazard_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       ID_AttemptBranch,
   input  logic       ID_BranchTaken,
   input  logic       ID_PredictBranchTaken,
   input  logic       ID_IsJALR,
   input  logic       EX_RegWrite,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_Rd,
   input  logic [4:0] ID_Rs1,
   input  logic [4:0] ID_Rs2,
   output logic       ID_Stall,
   output logic       mispredict,
   output logic       flush
);

   logic m1;
   logic m2;
   logic hz_lb;
   logic hz_lj;
   logic hz_lu;
   logic hz_ab;
   logic hz_aj;
   logic stall_ext_q;
   logic stall_ext_d;

   // Register-match and hazard classification; x0 never creates a dependency.
   always_comb begin
      m1    = (EX_Rd == ID_Rs1) && (EX_Rd != 5'd0);
      m2    = (EX_Rd == ID_Rs2) && (EX_Rd != 5'd0);
      // Load result reaches ID comparators two cycles late for branch/JALR.
      hz_lb = EX_MemRead && ID_AttemptBranch && (m1 || m2);
      hz_lj = EX_MemRead && ID_IsJALR && m1;
      hz_lu = EX_MemRead && !ID_AttemptBranch && !ID_IsJALR && (m1 || m2);
      // ALU result can be forwarded into ID after one bubble.
      hz_ab = EX_RegWrite && !EX_MemRead && ID_AttemptBranch && (m1 || m2);
      hz_aj = EX_RegWrite && !EX_MemRead && ID_IsJALR && m1;
   end

   // Extension arms only from an unextended cycle so a 2-cycle stall never
   // re-triggers itself into a third cycle.
   always_comb begin
      stall_ext_d = (hz_lb || hz_lj) && !stall_ext_q;
   end

   // Second-cycle stall extension; reset drops it without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_ext_q <= 1'b0;
      end else begin
         stall_ext_q <= stall_ext_d;
      end
   end

   // Outputs; a stalled branch is not resolved yet, so it cannot flush.
   always_comb begin
      ID_Stall   = hz_lb || hz_lj || hz_lu || hz_ab || hz_aj || stall_ext_q;
      mispredict = ID_AttemptBranch && (ID_BranchTaken != ID_PredictBranchTaken)
                   && !ID_Stall;
      flush      = mispredict;
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: each feature task drives vectors after the
// rising edge and compares outputs against hand-computed values.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       ID_AttemptBranch;
   logic       ID_BranchTaken;
   logic       ID_PredictBranchTaken;
   logic       ID_IsJALR;
   logic       EX_RegWrite;
   logic       EX_MemRead;
   logic [4:0] EX_Rd;
   logic [4:0] ID_Rs1;
   logic [4:0] ID_Rs2;
   logic       ID_Stall;
   logic       mispredict;
   logic       flush;

   int n_vec = 0;
   int n_err = 0;

   hazard_unit dut (
      .clk                   (clk),
      .rst                   (rst),
      .ID_AttemptBranch      (ID_AttemptBranch),
      .ID_BranchTaken        (ID_BranchTaken),
      .ID_PredictBranchTaken (ID_PredictBranchTaken),
      .ID_IsJALR             (ID_IsJALR),
      .EX_RegWrite           (EX_RegWrite),
      .EX_MemRead            (EX_MemRead),
      .EX_Rd                 (EX_Rd),
      .ID_Rs1                (ID_Rs1),
      .ID_Rs2                (ID_Rs2),
      .ID_Stall              (ID_Stall),
      .mispredict            (mispredict),
      .flush                 (flush)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      ID_AttemptBranch      = 1'b0;
      ID_BranchTaken        = 1'b0;
      ID_PredictBranchTaken = 1'b0;
      ID_IsJALR             = 1'b0;
      EX_RegWrite           = 1'b0;
      EX_MemRead            = 1'b0;
      EX_Rd                 = 5'd0;
      ID_Rs1                = 5'd0;
      ID_Rs2                = 5'd0;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flush two idle cycles so any extension from an earlier test is gone.
   task automatic settle();
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", ID_Stall); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", flush); end
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got %b want 0", mispredict); end
      // During reset outputs follow the combinational hazard terms.
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL reset_comb_stall got %b want 1", ID_Stall); end
      tick();
      clear_inputs();
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL reset_no_ext got %b want 0", ID_Stall); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_branch();
      settle();
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lb_c1_stall got %b want 1", ID_Stall); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL lb_c1_flush got %b want 0", flush); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lb_c2_stall got %b want 1", ID_Stall); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL lb_c2_flush got %b want 0", flush); end
      tick();
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lb_c3_stall got %b want 0", ID_Stall); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL lb_c3_flush got %b want 0", flush); end
      // Match on Rs2 also counts for a branch.
      settle();
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd9; ID_Rs1 = 5'd1; ID_Rs2 = 5'd9;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lb_rs2_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lb_rs2_c2 got %b want 1", ID_Stall); end
      // x0 never causes a hazard.
      settle();
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd0; ID_Rs1 = 5'd0; ID_Rs2 = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lb_x0 got %b want 0", ID_Stall); end
      tick();
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lb_x0_next got %b want 0", ID_Stall); end
   endtask

   task automatic test_load_jalr();
      settle();
      EX_MemRead = 1'b1; ID_IsJALR = 1'b1; EX_Rd = 5'd4; ID_Rs1 = 5'd4;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lj_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lj_c2 got %b want 1", ID_Stall); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL lj_c2_flush got %b want 0", flush); end
      tick();
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lj_c3 got %b want 0", ID_Stall); end
      // Rs2 is ignored for JALR.
      settle();
      EX_MemRead = 1'b1; ID_IsJALR = 1'b1; EX_Rd = 5'd4; ID_Rs1 = 5'd2; ID_Rs2 = 5'd4;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lj_rs2_ignored got %b want 0", ID_Stall); end
   endtask

   task automatic test_load_use();
      settle();
      EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rs1 = 5'd5;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lu_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lu_c2 got %b want 0", ID_Stall); end
      settle();
      EX_MemRead = 1'b1; EX_Rd = 5'd12; ID_Rs2 = 5'd12;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL lu_rs2_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL lu_rs2_c2 got %b want 0", ID_Stall); end
   endtask

   task automatic test_alu();
      settle();
      EX_RegWrite = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd6; ID_Rs1 = 5'd6;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL ab_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL ab_c2 got %b want 0", ID_Stall); end
      settle();
      EX_RegWrite = 1'b1; ID_IsJALR = 1'b1; EX_Rd = 5'd7; ID_Rs1 = 5'd7;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL aj_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL aj_c2 got %b want 0", ID_Stall); end
      // Non-writing EX instruction never stalls a branch.
      settle();
      ID_AttemptBranch = 1'b1; EX_Rd = 5'd6; ID_Rs1 = 5'd6;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL no_write got %b want 0", ID_Stall); end
      // Plain ALU result into a plain instruction is forwarded, no stall.
      settle();
      EX_RegWrite = 1'b1; EX_Rd = 5'd6; ID_Rs1 = 5'd6;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL alu_plain got %b want 0", ID_Stall); end
   endtask

   task automatic test_mispredict();
      settle();
      ID_AttemptBranch = 1'b1; ID_BranchTaken = 1'b1; ID_PredictBranchTaken = 1'b0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL mp_stall got %b want 0", ID_Stall); end
      n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL mp_mispredict got %b want 1", mispredict); end
      n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL mp_flush got %b want 1", flush); end
      ID_PredictBranchTaken = 1'b1;
      #1;
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL mp_correct_flush got %b want 0", flush); end
      ID_BranchTaken = 1'b0; ID_PredictBranchTaken = 1'b1;
      #1;
      n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL mp_nt_mispredict got %b want 1", mispredict); end
      // Mispredicting branch behind a load stall: no flush until stall ends.
      settle();
      ID_AttemptBranch = 1'b1; ID_BranchTaken = 1'b1; ID_PredictBranchTaken = 1'b0;
      EX_MemRead = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL mp_lb_c1_stall got %b want 1", ID_Stall); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL mp_lb_c1_flush got %b want 0", flush); end
      tick();
      EX_MemRead = 1'b0; EX_Rd = 5'd0;
      #1;
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL mp_lb_c2_flush got %b want 0", flush); end
      n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL mp_lb_c2_mispredict got %b want 0", mispredict); end
      tick();
      n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL mp_lb_c3_flush got %b want 1", flush); end
   endtask

   task automatic test_back_to_back();
      settle();
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd10; ID_Rs1 = 5'd10;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL b2b_c1 got %b want 1", ID_Stall); end
      tick();
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL b2b_c2 got %b want 1", ID_Stall); end
      tick();
      // Extension cleared on the re-detect edge, so removing the hazard ends it.
      clear_inputs();
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL b2b_c3 got %b want 0", ID_Stall); end
   endtask

   task automatic test_both();
      settle();
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; ID_IsJALR = 1'b1;
      EX_Rd = 5'd8; ID_Rs1 = 5'd9; ID_Rs2 = 5'd8;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL both_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL both_c2 got %b want 1", ID_Stall); end
      tick();
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL both_c3 got %b want 0", ID_Stall); end
   endtask

   task automatic test_reset_mid_stall();
      settle();
      EX_MemRead = 1'b1; ID_AttemptBranch = 1'b1; EX_Rd = 5'd3; ID_Rs1 = 5'd3;
      #1;
      n_vec++; if (ID_Stall !== 1'b1) begin n_err++; $display("FAIL rms_c1 got %b want 1", ID_Stall); end
      tick();
      EX_Rd = 5'd0;
      #1;
      rst = 1'b1;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL rms_async got %b want 0", ID_Stall); end
      tick();
      rst = 1'b0;
      #1;
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL rms_release got %b want 0", ID_Stall); end
      tick();
      n_vec++; if (ID_Stall !== 1'b0) begin n_err++; $display("FAIL rms_after got %b want 0", ID_Stall); end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_load_branch();
      test_load_jalr();
      test_load_use();
      test_alu();
      test_mispredict();
      test_back_to_back();
      test_both();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
